ram_req_controller: RTL and testbench

- Request/response front end that sits directly upstream of single_port_ram and drives its we/addr/data_in, capturing its data_out.
- After reset it clears every RAM location to INIT_VALUE.
- It then serves one read or write request at a time over valid/ready handshakes, returning read data on a held response channel.

---
 rtl/ram_req_controller.sv | 99 +++++++++
 tb/tb_ram_req_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_controller.sv
// Request/response front end for single_port_ram: clears the RAM after reset,
// then serves one read or write at a time over valid/ready handshakes.
module ram_req_controller #(
  parameter int                DEPTH      = 8,
  parameter int                WIDTH      = 8,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     init_done,
  output logic                     ram_we,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [WIDTH-1:0]         ram_wdata,
  input  logic [WIDTH-1:0]         ram_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_RD2  = 3'd3;
  localparam logic [2:0] ST_RD3  = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  logic [2:0]    state;
  logic [AW-1:0] init_cnt;

  assign req_ready = (state == ST_IDLE) && !rsp_valid;

  // The clear ends once the write to the last address has been issued, so
  // init_cnt can saturate at LAST_ADDR instead of needing an extra bit.
  // Reads spend RD1..RD3 waiting on the RAM, giving a three-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (ram_we && (ram_addr == LAST_ADDR)) begin
            ram_we    <= 1'b0;
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            ram_we    <= 1'b1;
            ram_addr  <= init_cnt;
            ram_wdata <= INIT_VALUE;
            if (init_cnt != LAST_ADDR) begin
              init_cnt <= init_cnt + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          ram_we <= 1'b0;
          if (req_valid && req_ready) begin
            ram_addr <= req_addr;
            if (req_we) begin
              ram_we    <= 1'b1;
              ram_wdata <= req_wdata;
            end else begin
              state <= ST_RD1;
            end
          end
        end
        ST_RD1: state <= ST_RD2;
        ST_RD2: state <= ST_RD3;
        ST_RD3: begin
          rsp_data  <= ram_rdata;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_controller.sv
// Directed bench for ram_req_controller with a behavioural single-port RAM
// attached to its RAM-side ports.
module tb_ram_req_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       init_done;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  logic [7:0] mem [8];

  int checks = 0;
  int errors = 0;

  ram_req_controller #(.DEPTH(8), .WIDTH(8), .INIT_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-write, synchronous-read RAM; starts with junk so the clear is visible.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'hAA;
    ram_rdata = 8'hAA;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] addr, output logic [7:0] data, output bit ok);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    ok   = rsp_valid;
    data = rsp_data;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata, rsp_valid, rsp_data, init_done, req_ready} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got we=%b addr=%h wd=%h rv=%b rd=%h id=%b rr=%b required all zero",
               ram_we, ram_addr, ram_wdata, rsp_valid, rsp_data, init_done, req_ready);
    end
  endtask

  task automatic test_init();
    logic [7:0] d;
    bit ok;
    release_reset();
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 3'(n - 1) || ram_wdata !== 8'h00 || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL init_edge%0d: got we=%b addr=%0d wd=%h rr=%b required we=1 addr=%0d wd=00 rr=0",
                 n, ram_we, ram_addr, ram_wdata, req_ready, n - 1);
      end
    end
    tick();
    checks++;
    if (ram_we !== 1'b0 || init_done !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_finish: got we=%b id=%b rr=%b required we=0 id=1 rr=1",
               ram_we, init_done, req_ready);
    end
    do_read(3'd3, d, ok);
    checks++;
    if (!ok || d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL init_read3: got ok=%b data=%h required ok=1 data=00", ok, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    bit ok;
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 3'(i); req_wdata = 8'h10 + 8'(i);
      tick();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 3'(i) || ram_wdata !== 8'h10 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL b2b_write%0d: got we=%b addr=%0d wd=%h required we=1 addr=%0d wd=%h",
                 i, ram_we, ram_addr, ram_wdata, i, 8'h10 + 8'(i));
      end
    end
    req_valid = 1'b0;
    tick();
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_we_drop: got we=%b required 0", ram_we);
    end
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), d, ok);
      checks++;
      if (!ok || d !== 8'h10 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL b2b_read%0d: got ok=%b data=%h required %h", i, ok, d, 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_latency();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd4;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 3'd4) begin
        errors++;
        $display("[TB] FAIL latency_E+%0d: got rv=%b rr=%b we=%b addr=%0d required rv=0 rr=0 we=0 addr=4",
                 k - 1, rsp_valid, req_ready, ram_we, ram_addr);
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h14 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_E+3: got rv=%b rd=%h rr=%b required rv=1 rd=14 rr=0",
               rsp_valid, rsp_data, req_ready);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_consume: got rv=%b rr=%b required rv=0 rr=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    // A write waiting while the response is held must not reach the RAM.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_wdata = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h12 || req_ready !== 1'b0 || ram_we !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got rv=%b rd=%h rr=%b we=%b required rv=1 rd=12 rr=0 we=0",
                 k, rsp_valid, rsp_data, req_ready, ram_we);
      end
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 8'h12) begin
      errors++;
      $display("[TB] FAIL hold_release: got rv=%b rr=%b rd=%h required rv=0 rr=1 rd=12",
               rsp_valid, req_ready, rsp_data);
    end
  endtask

  task automatic test_reset_midread();
    logic [7:0] d;
    bit ok;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 8'h15;
    tick();
    req_valid = 1'b0;
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0 || ram_we !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midread_reset: got rv=%b id=%b rr=%b we=%b rd=%h required all zero",
               rsp_valid, init_done, req_ready, ram_we, rsp_data);
    end
    release_reset();
    repeat (9) tick();
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midread_reinit: got id=%b rr=%b required id=1 rr=1", init_done, req_ready);
    end
    do_read(3'd5, d, ok);
    checks++;
    if (!ok || d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midread_read5: got ok=%b data=%h required 00", ok, d);
    end
  endtask

  task automatic test_req_during_init();
    logic [7:0] d;
    bit ok;
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd0; req_wdata = 8'h5A;
    release_reset();
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 3'(n - 1) || ram_wdata !== 8'h00) begin
        errors++;
        $display("[TB] FAIL busy_init_edge%0d: got we=%b addr=%0d wd=%h required we=1 addr=%0d wd=00",
                 n, ram_we, ram_addr, ram_wdata, n - 1);
      end
    end
    tick();
    checks++;
    if (ram_we !== 1'b0 || init_done !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_init_finish: got we=%b id=%b rr=%b required we=0 id=1 rr=1",
               ram_we, init_done, req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 3'd0 || ram_wdata !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL busy_first_accept: got we=%b addr=%0d wd=%h required we=1 addr=0 wd=5a",
               ram_we, ram_addr, ram_wdata);
    end
    tick();
    do_read(3'd0, d, ok);
    checks++;
    if (!ok || d !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL busy_read0: got ok=%b data=%h required 5a", ok, d);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_back_to_back();
    test_latency();
    test_backpressure();
    test_reset_midread();
    test_req_during_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
